// File: rtl/sw_count_seg_driver.sv
// sw_count_seg_driver
// -------------------
// Front end for the 7-segment display monitor. It synchronizes and debounces
// an active-low pushbutton and counts presses modulo MODULUS. While the button
// is held, the count auto-repeats. The current digit is driven as a registered
// active-low segment pattern.
//
// Ports
//   clk          system clock; all state changes on the rising edge
//   rst          synchronous reset, active-high, dominant over everything
//   sw_n         raw pushbutton, active-low (0 = pressed), asynchronous to clk
//   segout[7:0]  active-low segments: 7=dp 6=a 5=b 4=c 3=d 2=e 1=f 0=g
//   count[3:0]   current count, binary
//   press_pulse  one-cycle strobe on every increment (initial or repeat)
//   o_dbg_state  current press FSM state (IDLE=0, HELD=1, REPEAT=2)
//
// Timing, for DEBOUNCE_CYCLES = D, with sw_n first sampled low at edge k:
//   s2 is low after edge k+1.
//   The debounced level goes low after edge k+1+D.
//   count and press_pulse change at edge k+2+D.
//   segout follows one edge later.
// The first auto-repeat comes HOLD_CYCLES cycles after the initial increment.
// Later repeats come every REPEAT_CYCLES cycles.
module sw_count_seg_driver #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int HOLD_CYCLES     = 16,
  parameter int REPEAT_CYCLES   = 4,
  parameter int MODULUS         = 10
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sw_n,
  output logic [7:0] segout,
  output logic [3:0] count,
  output logic       press_pulse,
  output logic [1:0] o_dbg_state
);

  localparam int DW   = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int TMAX = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
  localparam int TW   = $clog2(TMAX + 1);

  localparam logic [DW-1:0] DB_LAST     = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [TW-1:0] HOLD_LAST   = TW'(HOLD_CYCLES - 1);
  localparam logic [TW-1:0] REPEAT_LAST = TW'(REPEAT_CYCLES - 1);
  localparam logic [3:0]    MOD_LAST    = 4'(MODULUS - 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_HELD   = 2'd1,
    ST_REPEAT = 2'd2
  } state_t;

  // Synchronizer and debouncer state
  logic          r_s1;
  logic          r_s2;
  logic          r_db;       // debounced level, 1 = released
  logic [DW-1:0] r_db_cnt;

  // Press FSM and datapath
  state_t        r_state;
  logic [TW-1:0] r_timer;
  logic [3:0]    r_count;
  logic          r_pulse;
  logic [7:0]    r_seg;

  state_t        w_state_nxt;
  logic [TW-1:0] w_timer_nxt;
  logic          w_inc;
  logic [3:0]    w_count_nxt;

  // Segments a..g for one hex digit, active-low, dp excluded
  function automatic logic [6:0] seg_pattern(input logic [3:0] d);
    logic [6:0] p;
    case (d)
      4'h0:    p = 7'h01;
      4'h1:    p = 7'h4F;
      4'h2:    p = 7'h12;
      4'h3:    p = 7'h06;
      4'h4:    p = 7'h4C;
      4'h5:    p = 7'h24;
      4'h6:    p = 7'h20;
      4'h7:    p = 7'h0F;
      4'h8:    p = 7'h00;
      4'h9:    p = 7'h04;
      4'hA:    p = 7'h08;
      4'hB:    p = 7'h60;
      4'hC:    p = 7'h31;
      4'hD:    p = 7'h42;
      4'hE:    p = 7'h30;
      default: p = 7'h38;
    endcase
    return p;
  endfunction

  // Two-flop synchronizer followed by a run-length debouncer.
  // While s2 differs from the debounced level, the counter grows.
  // A disagreement lasting DEBOUNCE_CYCLES cycles flips the level.
  // Any agreement restarts the count.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1     <= 1'b1;
      r_s2     <= 1'b1;
      r_db     <= 1'b1;
      r_db_cnt <= '0;
    end else begin
      r_s1 <= sw_n;
      r_s2 <= r_s1;
      if (r_s2 == r_db) begin
        r_db_cnt <= '0;
      end else if (r_db_cnt == DB_LAST) begin
        r_db     <= r_s2;
        r_db_cnt <= '0;
      end else begin
        r_db_cnt <= r_db_cnt + 1'b1;
      end
    end
  end

  // Next-state logic. A release is checked before the timer,
  // so a release always wins over a coincident timer expiry.
  always_comb begin
    w_state_nxt = r_state;
    w_timer_nxt = r_timer;
    w_inc       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (!r_db) begin
          w_inc       = 1'b1;
          w_timer_nxt = '0;
          w_state_nxt = ST_HELD;
        end
      end
      ST_HELD: begin
        if (r_db) begin
          w_state_nxt = ST_IDLE;
        end else if (r_timer == HOLD_LAST) begin
          w_inc       = 1'b1;
          w_timer_nxt = '0;
          w_state_nxt = ST_REPEAT;
        end else begin
          w_timer_nxt = r_timer + 1'b1;
        end
      end
      ST_REPEAT: begin
        if (r_db) begin
          w_state_nxt = ST_IDLE;
        end else if (r_timer == REPEAT_LAST) begin
          w_inc       = 1'b1;
          w_timer_nxt = '0;
        end else begin
          w_timer_nxt = r_timer + 1'b1;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_timer_nxt = '0;
      end
    endcase

    w_count_nxt = r_count;
    if (w_inc) begin
      w_count_nxt = (r_count == MOD_LAST) ? 4'd0 : r_count + 4'd1;
    end
  end

  // The segment register samples the already-registered count and state.
  // The display therefore trails count by one cycle. The dp lags the
  // REPEAT state by the same amount.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_timer <= '0;
      r_count <= 4'd0;
      r_pulse <= 1'b0;
      r_seg   <= 8'h81;
    end else begin
      r_state <= w_state_nxt;
      r_timer <= w_timer_nxt;
      r_count <= w_count_nxt;
      r_pulse <= w_inc;
      r_seg   <= {(r_state != ST_REPEAT), seg_pattern(r_count)};
    end
  end

  assign segout      = r_seg;
  assign count       = r_count;
  assign press_pulse = r_pulse;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_sw_count_seg_driver.sv
// Testbench for sw_count_seg_driver (default parameters).
// The directed tasks check the documented latencies against constants.
// The random task checks every cycle against a press model.
// The model works in terms of debounce run lengths and hold age.
module tb_sw_count_seg_driver;

  localparam int D = 4;
  localparam int H = 16;
  localparam int R = 4;
  localparam int M = 10;

  logic       clk = 1'b0;
  logic       rst;
  logic       sw_n;
  logic [7:0] segout;
  logic [3:0] count;
  logic       press_pulse;
  logic [1:0] dbg_state;

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0] enc_tab [16];

  sw_count_seg_driver #(
    .DEBOUNCE_CYCLES(D),
    .HOLD_CYCLES(H),
    .REPEAT_CYCLES(R),
    .MODULUS(M)
  ) dut (
    .clk(clk),
    .rst(rst),
    .sw_n(sw_n),
    .segout(segout),
    .count(count),
    .press_pulse(press_pulse),
    .o_dbg_state(dbg_state)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  logic       m_s1, m_s2, m_db;
  int         m_run;
  int         m_age;    // cycles since the initial increment; -1 when not held
  logic [3:0] m_count;
  logic       m_pulse;
  logic       m_rep;
  logic [7:0] m_seg;

  task automatic model_edge(input logic v, input logic r);
    logic [3:0] old_count;
    logic       old_rep;
    logic       old_db;
    logic       inc;
    if (r) begin
      m_s1 = 1'b1; m_s2 = 1'b1; m_db = 1'b1; m_run = 0; m_age = -1;
      m_count = 4'd0; m_pulse = 1'b0; m_rep = 1'b0; m_seg = 8'h81;
    end else begin
      old_count = m_count;
      old_rep   = m_rep;
      old_db    = m_db;
      // Display shows the previous cycle's digit and repeat status
      m_seg = enc_tab[old_count];
      if (old_rep) m_seg[7] = 1'b0;
      // Increment schedule:
      //   initial press at age 0,
      //   then at age H,
      //   then every R cycles after that.
      inc = 1'b0;
      if (old_db) begin
        m_age = -1;
      end else if (m_age < 0) begin
        m_age = 0;
        inc = 1'b1;
      end else begin
        m_age = m_age + 1;
        if (m_age == H || (m_age > H && ((m_age - H) % R) == 0)) inc = 1'b1;
      end
      m_pulse = inc;
      if (inc) m_count = 4'((int'(m_count) + 1) % M);
      m_rep = (m_age >= H);
      // Level flips after D consecutive disagreeing synchronized samples
      if (m_s2 != m_db) begin
        m_run = m_run + 1;
        if (m_run == D) begin
          m_db = m_s2;
          m_run = 0;
        end
      end else begin
        m_run = 0;
      end
      m_s2 = m_s1;
      m_s1 = v;
    end
  endtask

  // ---------------- driver tasks ----------------
  // One clock: inputs set beforehand are sampled at this edge,
  // and outputs are observed 1 time unit later.
  task automatic tick();
    logic v, r;
    @(posedge clk);
    v = sw_n;
    r = rst;
    model_edge(v, r);
    #1;
  endtask

  task automatic do_reset(input logic lvl);
    rst  = 1'b1;
    sw_n = lvl;
    tick();
    tick();
    rst = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst  = 1'b1;
    sw_n = 1'b1;
    tick();
    tick();
    n_tests++;
    if (segout !== 8'h81) begin
      n_fail++; $display("FAIL reset_segout got %h exp 81", segout);
    end
    n_tests++;
    if (count !== 4'd0) begin
      n_fail++; $display("FAIL reset_count got %0d exp 0", count);
    end
    n_tests++;
    if (press_pulse !== 1'b0) begin
      n_fail++; $display("FAIL reset_pulse got %b exp 0", press_pulse);
    end
    rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      n_tests++;
      if (segout !== 8'h81 || count !== 4'd0 || press_pulse !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_idle cyc %0d got seg=%h cnt=%0d p=%b exp 81/0/0",
                 i, segout, count, press_pulse);
      end
    end
  endtask

  task automatic test_clean_press();
    logic [3:0] exp_c;
    logic [7:0] exp_s;
    logic       exp_p;
    do_reset(1'b1);
    for (int j = 0; j < 30; j++) begin
      sw_n = (j < 10) ? 1'b0 : 1'b1;
      tick();
      exp_p = (j == 6);
      exp_c = (j >= 6) ? 4'd1 : 4'd0;
      exp_s = (j >= 7) ? 8'hCF : 8'h81;
      n_tests++;
      if (press_pulse !== exp_p || count !== exp_c || segout !== exp_s) begin
        n_fail++;
        $display("FAIL clean_press edge k+%0d got p=%b cnt=%0d seg=%h exp p=%b cnt=%0d seg=%h",
                 j, press_pulse, count, segout, exp_p, exp_c, exp_s);
      end
    end
  endtask

  task automatic test_glitch();
    do_reset(1'b1);
    for (int j = 0; j < 13; j++) begin
      sw_n = (j < 3) ? 1'b0 : 1'b1;
      tick();
      n_tests++;
      if (press_pulse !== 1'b0 || count !== 4'd0 || segout !== 8'h81) begin
        n_fail++;
        $display("FAIL glitch edge %0d got p=%b cnt=%0d seg=%h exp 0/0/81",
                 j, press_pulse, count, segout);
      end
    end
  endtask

  task automatic test_wrap();
    int pulses;
    pulses = 0;
    do_reset(1'b1);
    for (int p = 0; p < 10; p++) begin
      for (int j = 0; j < 20; j++) begin
        sw_n = (j < 10) ? 1'b0 : 1'b1;
        tick();
        if (press_pulse === 1'b1) pulses++;
      end
      n_tests++;
      if (segout !== enc_tab[(p + 1) % 10] || count !== 4'((p + 1) % 10)) begin
        n_fail++;
        $display("FAIL wrap press %0d got seg=%h cnt=%0d exp seg=%h cnt=%0d",
                 p, segout, count, enc_tab[(p + 1) % 10], (p + 1) % 10);
      end
    end
    n_tests++;
    if (pulses != 10) begin
      n_fail++; $display("FAIL wrap_pulses got %0d exp 10", pulses);
    end
    n_tests++;
    if (count !== 4'd0) begin
      n_fail++; $display("FAIL wrap_final_count got %0d exp 0", count);
    end
  endtask

  task automatic test_auto_repeat();
    int   t;
    logic exp_p, exp_dp;
    do_reset(1'b1);
    for (int j = 0; j < 60; j++) begin
      sw_n = (j < 40) ? 1'b0 : 1'b1;
      tick();
      t = j - 6;
      // The debounced release reaches the FSM at edge k+46, so t = 39 is the last chance
      exp_p  = (t == 0) || (t >= H && t <= 39 && ((t - H) % R) == 0);
      exp_dp = !(j >= 23 && j <= 46);
      n_tests++;
      if (press_pulse !== exp_p || segout[7] !== exp_dp) begin
        n_fail++;
        $display("FAIL auto_repeat edge k+%0d got p=%b dp=%b exp p=%b dp=%b",
                 j, press_pulse, segout[7], exp_p, exp_dp);
      end
    end
    n_tests++;
    if (count !== 4'd7) begin
      n_fail++; $display("FAIL auto_repeat_count got %0d exp 7", count);
    end
  endtask

  task automatic test_reset_mid_hold();
    logic [3:0] exp_c;
    logic [7:0] exp_s;
    logic       exp_p;
    do_reset(1'b1);
    sw_n = 1'b0;
    for (int j = 0; j < 30; j++) tick();
    n_tests++;
    if (segout[7] !== 1'b0) begin
      n_fail++; $display("FAIL mid_hold_in_repeat dp got %b exp 0", segout[7]);
    end
    rst = 1'b1;
    tick();
    tick();
    n_tests++;
    if (segout !== 8'h81 || count !== 4'd0 || press_pulse !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_hold_reset got seg=%h cnt=%0d p=%b exp 81/0/0",
               segout, count, press_pulse);
    end
    rst = 1'b0;
    for (int j = 0; j < 15; j++) begin
      tick();
      exp_p = (j == 6);
      exp_c = (j >= 6) ? 4'd1 : 4'd0;
      exp_s = (j >= 7) ? 8'hCF : 8'h81;
      n_tests++;
      if (press_pulse !== exp_p || count !== exp_c || segout !== exp_s) begin
        n_fail++;
        $display("FAIL mid_hold_repress edge %0d got p=%b cnt=%0d seg=%h exp p=%b cnt=%0d seg=%h",
                 j, press_pulse, count, segout, exp_p, exp_c, exp_s);
      end
    end
  endtask

  task automatic test_random();
    int   cyc;
    int   len;
    logic lvl;
    cyc = 0;
    do_reset(1'b1);
    while (cyc < 1500) begin
      lvl = 1'($urandom_range(0, 1));
      len = $urandom_range(0, 3) == 0 ? $urandom_range(1, 5) : $urandom_range(1, 40);
      for (int i = 0; i < len; i++) begin
        sw_n = lvl;
        tick();
        cyc++;
        n_tests++;
        if (count !== m_count || press_pulse !== m_pulse || segout !== m_seg) begin
          n_fail++;
          $display("FAIL random cyc %0d got cnt=%0d p=%b seg=%h exp cnt=%0d p=%b seg=%h",
                   cyc, count, press_pulse, segout, m_count, m_pulse, m_seg);
        end
      end
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    enc_tab = '{8'h81, 8'hCF, 8'h92, 8'h86, 8'hCC, 8'hA4, 8'hA0, 8'h8F,
                8'h80, 8'h84, 8'h88, 8'hE0, 8'hB1, 8'hC2, 8'hB0, 8'hB8};
    rst  = 1'b1;
    sw_n = 1'b1;
    model_edge(1'b1, 1'b1);
    test_reset();
    test_clean_press();
    test_glitch();
    test_wrap();
    test_auto_repeat();
    test_reset_mid_hold();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/sw_count_seg_driver.md
Name: sw_count_seg_driver

Overview:
- Upstream stage feeding the 7-segment display monitor.
- Synchronizes and debounces the active-low pushbutton `sw_n`.
- Counts presses modulo MODULUS, with auto-repeat while the button is held.
- Drives the registered, active-low 8-bit pattern on `segout`, which the display consumes every clock.

Parameters:
- DEBOUNCE_CYCLES, 4: consecutive synchronized cycles of a new level needed before the debounced level changes (>=1).
- HOLD_CYCLES, 16: cycles from the initial increment to the first auto-repeat increment (>=2).
- REPEAT_CYCLES, 4: cycles between auto-repeat increments (>=1).
- MODULUS, 10: count range 0..MODULUS-1 (2..16).

Ports:
- clk  input  1  system clock, all logic on rising edge.
- rst  input  1  synchronous reset, active-high.
- sw_n  input  1  raw pushbutton, active-low (0 = pressed), asynchronous to clk.
- segout  output  8  active-low segments: bit7=dp, 6=a(top), 5=b(upper right), 4=c(lower right), 3=d(bottom), 2=e(lower left), 1=f(upper left), 0=g(middle).
- count  output  4  current count, binary.
- press_pulse  output  1  one-cycle strobe on every increment (initial or repeat).

Behaviour:
- One clock domain, clk; synchronous active-high reset rst. All state changes on rising clk.
- Reset, dominant over everything:
  - sync flops = 1, debounced level = 1 (released), debounce counter = 0.
  - FSM = IDLE, timer = 0, count = 0, press_pulse = 0.
  - segout = 8'h81 (digit 0, dp off).
- Synchronizer: two flops on sw_n, named s1 and s2.
- Debouncer:
  - When s2 == debounced level, the counter clears.
  - Otherwise it increments. When it reaches DEBOUNCE_CYCLES-1 and s2 still differs, the debounced level takes s2 at the next edge and the counter clears.
  - Pulses shorter than DEBOUNCE_CYCLES synchronized cycles are ignored.
- FSM states and transitions:
  - IDLE: debounced low → increment count, pulse, clear timer, go to HELD.
  - HELD: debounced high → IDLE. Else when timer == HOLD_CYCLES-1 → increment, pulse, clear timer, go to REPEAT. Else timer++.
  - REPEAT: debounced high → IDLE. Else when timer == REPEAT_CYCLES-1 → increment, pulse, clear timer. Else timer++.
  - Release takes priority over a coincident timer expiry: no increment in that cycle.
- Increment: count == MODULUS-1 wraps to 0, else count+1. count and press_pulse update on the same edge.
- Latency:
  - If sw_n is first sampled low at edge k and held: s2 low after edge k+1; debounced low after edge k+1+DEBOUNCE_CYCLES.
  - count and press_pulse change at edge k+2+DEBOUNCE_CYCLES.
  - segout reflects the new count one edge later.
- Timing of later increments: first repeat exactly HOLD_CYCLES cycles after the initial increment, then every REPEAT_CYCLES.
- segout, registered from count and state:
  - bits[6:0] from the encoding table below.
  - bit7 = 0 (dp lit) while the FSM is in REPEAT, else 1; lags the state by one cycle like the digit.
- Encoding, hex digit → segout with dp off: 0=81 1=CF 2=92 3=86 4=CC 5=A4 6=A0 7=8F
- Encoding, continued: 8=80 9=84 A=88 b=E0 C=B1 d=C2 E=B0 F=B8. Only digits < MODULUS are reachable.
- Reset mid-press: all state returns to reset values. If sw_n is still low after rst deasserts, it is treated as a new press: one increment after the full sync+debounce latency.
- Bounce during REPEAT shorter than DEBOUNCE_CYCLES does not leave REPEAT.

Test Plan:
- Defaults for all tests: DEBOUNCE_CYCLES=4, HOLD_CYCLES=16, REPEAT_CYCLES=4, MODULUS=10.
- Reset: rst=1 for 2 cycles with sw_n=1 → segout=8'h81, count=0, press_pulse=0; stable for 20 further idle cycles.
- Clean press: sw_n=0 from edge k for 10 cycles, then 1 → press_pulse high only in the cycle after edge k+6; count=1 from edge k+6; segout=8'hCF from edge k+7; no further change.
- Glitch rejection: sw_n=0 for 3 cycles, then 1 for 10 cycles → count stays 0, press_pulse never asserted, segout=8'h81.
- Wrap: 10 clean presses, each 10 cycles low / 10 high → segout sequence CF,92,86,CC,A4,A0,8F,80,84,81; count ends at 0; exactly 10 pulses.
- Auto-repeat: hold sw_n=0 for 40 cycles from count 0 → increments at relative cycles 0, 16, 20, 24, ... until released; segout bit7=0 from the cycle after entering REPEAT, back to 1 after release.
- Reset mid-hold: assert rst while in REPEAT with sw_n still 0, release after 2 cycles → segout=8'h81, bit7=1; one increment to count=1 exactly 6 edges after rst deasserts.
